// File: rtl/axi_pkg.sv
// Shared definitions for the data-cache to AXI bridge.
// Contents:
//   state_t         - bridge FSM state encoding
//   SZ_*            - cache request size codes (these are also the low bits of AXI AxSIZE)
//   AXI_*           - single-beat tie-off values: burst type, length, id, last
//   phys_addr()     - virtual to physical address mapping
package axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WRESP = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
  localparam logic [3:0] AXI_ID_ZERO     = 4'd0;
  localparam logic       AXI_LAST_SINGLE = 1'b1;

  // The kseg0/kseg1 windows (a[31:30] = 2'b10) alias low physical memory.
  // Clearing bits [31:29] removes both the segment bits and the cached or
  // uncached selector. Every other address passes through untouched.
  function automatic logic [31:0] phys_addr(input logic [31:0] va);
    return (va[31:30] == 2'b10) ? {3'b000, va[28:0]} : va;
  endfunction

endpackage

// File: rtl/dcache_axi_bridge_if.sv
// Bus bundle between the data cache, the bridge and an AXI slave.
// Signals:
//   cache side : m_a, m_din, m_strobe, m_rw, m_size (requests in), m_dout, m_ready (results out)
//   AR channel : araddr, arsize, arlen, arburst, arid, arvalid / arready
//   R channel  : rdata, rvalid / rready
//   AW channel : awaddr, awsize, awlen, awburst, awid, awvalid / awready
//   W channel  : wdata, wstrb, wlast, wvalid / wready
//   B channel  : bvalid / bready
// Modports:
//   master - the bridge, which is the AXI master.
//   slave  - the environment: the cache requester together with the AXI slave.
interface dcache_axi_bridge_if;

  logic [31:0] m_a;
  logic [31:0] m_din;
  logic        m_strobe;
  logic        m_rw;
  logic [1:0]  m_size;
  logic [31:0] m_dout;
  logic        m_ready;

  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic [3:0]  awid;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic        bvalid;
  logic        bready;

  modport master (
    input  m_a, m_din, m_strobe, m_rw, m_size,
    output m_dout, m_ready,
    output araddr, arsize, arlen, arburst, arid, arvalid,
    input  arready,
    input  rdata, rvalid,
    output rready,
    output awaddr, awsize, awlen, awburst, awid, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    output m_a, m_din, m_strobe, m_rw, m_size,
    input  m_dout, m_ready,
    input  araddr, arsize, arlen, arburst, arid, arvalid,
    output arready,
    output rdata, rvalid,
    input  rready,
    input  awaddr, awsize, awlen, awburst, awid, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );

endinterface

// File: rtl/strb_gen.sv
// Combinational decode of a latched request size into an AXI write strobe
// and an AXI AxSIZE code.
// Ports:
//   i_size    - request size: 00 byte, 01 half, 10 word, 11 handled as word
//   i_addr_lo - low two bits of the request address
//   o_strb    - byte-lane write strobe
//   o_axsize  - AXI AxSIZE value
module strb_gen
  import axi_pkg::*;
(
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_strb,
  output logic [2:0] o_axsize
);

  always_comb begin
    // The default covers both word and the unused 2'b11 code.
    o_strb   = 4'b1111;
    o_axsize = {1'b0, SZ_WORD};
    case (i_size)
      SZ_BYTE: begin
        o_strb   = 4'b0001 << i_addr_lo;
        o_axsize = {1'b0, SZ_BYTE};
      end
      SZ_HALF: begin
        // Halfwords are aligned, so only a[1] selects the lane pair.
        o_strb   = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_axsize = {1'b0, SZ_HALF};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dcache_axi_bridge.sv
// Converts single data-cache requests into single-beat AXI transfers.
// Ports:
//   clk  - sole clock
//   rst  - asynchronous active-high reset; abandons any transfer in flight
//   bus  - dcache_axi_bridge_if.master: cache request/response and AXI channels
// A request is accepted in IDLE. One AR/R or AW+W/B exchange follows, then
// m_ready pulses for one cycle. All AXI outputs come from the request
// registers or the state, never directly from the m_* inputs.
module dcache_axi_bridge
  import axi_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  dcache_axi_bridge_if.master bus
);

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_a;
  logic [31:0] r_din;
  logic        r_rw;
  logic [1:0]  r_size;
  logic [31:0] r_m_dout;
  logic        r_aw_done;
  logic        r_w_done;

  logic        w_ar_hs;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic [31:0] w_paddr;
  logic [3:0]  w_strb;
  logic [2:0]  w_axsize;

  assign w_ar_hs = bus.arvalid & bus.arready;
  assign w_aw_hs = bus.awvalid & bus.awready;
  assign w_w_hs  = bus.wvalid & bus.wready;

  strb_gen u_strb_gen (
    .i_size    (r_size),
    .i_addr_lo (r_a[1:0]),
    .o_strb    (w_strb),
    .o_axsize  (w_axsize)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.m_strobe) w_state_next = bus.m_rw ? ST_WADDR : ST_RADDR;
      ST_RADDR: if (w_ar_hs)      w_state_next = ST_RDATA;
      ST_RDATA: if (bus.rvalid)   w_state_next = ST_DONE;
      // AW and W may complete in either order or in the same cycle.
      ST_WADDR: if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_state_next = ST_WRESP;
      ST_WRESP: if (bus.bvalid)   w_state_next = ST_DONE;
      ST_DONE:                    w_state_next = ST_IDLE;
      default:                    w_state_next = ST_IDLE;
    endcase
  end

  // Output logic: depends only on the state and the done flags.
  always_comb begin
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.m_ready = 1'b0;
    case (r_state)
      ST_RADDR: bus.arvalid = 1'b1;
      ST_RDATA: bus.rready  = 1'b1;
      ST_WADDR: begin
        bus.awvalid = ~r_aw_done;
        bus.wvalid  = ~r_w_done;
      end
      ST_WRESP: bus.bready  = 1'b1;
      ST_DONE:  bus.m_ready = 1'b1;
      default: ;
    endcase
  end

  // Request registers. m_strobe is only honoured in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_din  <= '0;
      r_rw   <= 1'b0;
      r_size <= '0;
    end else if (r_state == ST_IDLE && bus.m_strobe) begin
      r_a    <= bus.m_a;
      r_din  <= bus.m_din;
      r_rw   <= bus.m_rw;
      r_size <= bus.m_size;
    end
  end

  // Per-channel completion flags for the write address/data pair. They are
  // cleared whenever the bridge is outside WADDR, so each write starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_state == ST_WADDR) begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end else begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end
  end

  // Read data is held until the next read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_m_dout <= '0;
    else if (r_state == ST_RDATA && bus.rvalid && !r_rw) r_m_dout <= bus.rdata;
  end

  assign w_paddr     = phys_addr(r_a);
  assign bus.m_dout  = r_m_dout;

  assign bus.araddr  = w_paddr;
  assign bus.arsize  = w_axsize;
  assign bus.arlen   = AXI_LEN_SINGLE;
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arid    = AXI_ID_ZERO;

  assign bus.awaddr  = w_paddr;
  assign bus.awsize  = w_axsize;
  assign bus.awlen   = AXI_LEN_SINGLE;
  assign bus.awburst = AXI_BURST_INCR;
  assign bus.awid    = AXI_ID_ZERO;

  assign bus.wdata   = r_din;
  assign bus.wstrb   = w_strb;
  assign bus.wlast   = AXI_LAST_SINGLE;

endmodule

// File: doc/dcache_axi_bridge.md
DCACHE_AXI_BRIDGE -- requirements
Module: dcache_axi_bridge

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port m_a  input  32  request virtual address from data cache.
REQ-004 SHALL have port m_din  input  32  write data, already byte-lane positioned.
REQ-005 SHALL have port m_strobe  input  1  request valid, held until m_ready.
REQ-006 SHALL have port m_rw  input  1  0 read, 1 write.
REQ-007 SHALL have port m_size  input  2  00 byte, 01 half, 10 word.
REQ-008 SHALL have port m_dout  output  32  read data returned to cache.
REQ-009 SHALL have port m_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports araddr out 32, arsize out 3, arvalid out 1, arready in 1  AXI read address channel.
REQ-011 SHALL have ports rdata in 32, rvalid in 1, rready out 1  AXI read data channel.
REQ-012 SHALL have ports awaddr out 32, awsize out 3, awvalid out 1, awready in 1  AXI write address channel.
REQ-013 SHALL have ports wdata out 32, wstrb out 4, wvalid out 1, wready in 1  AXI write data channel.
REQ-014 SHALL have ports bvalid in 1, bready out 1  AXI write response channel.

Function
REQ-015 SHALL implement FSM states IDLE, RADDR, RDATA, WADDR, WRESP, DONE.
REQ-016 In IDLE with m_strobe=1, SHALL latch m_a, m_din, m_rw, m_size into request registers and go to RADDR (m_rw=0) or WADDR (m_rw=1); m_strobe ignored in every other state.
REQ-017 All AXI outputs SHALL be driven only from request registers, never combinationally from m_* inputs.
REQ-018 Physical address SHALL be {3'b000, a[28:0]} when a[31:30]=2'b10 (kseg0/kseg1), else a unchanged; same value on araddr and awaddr.
REQ-019 arsize/awsize SHALL equal {1'b0, size}; size 2'b11 treated as word.
REQ-020 wstrb SHALL be 0001<<a[1:0] for byte, 0011<<{a[1],0} for half, 1111 for word; wdata = latched m_din unshifted.
REQ-021 RADDR: arvalid=1; on arvalid&arready go to RDATA next cycle.
REQ-022 RDATA: rready=1; on rvalid capture rdata into m_dout register, go to DONE.
REQ-023 WADDR: awvalid and wvalid asserted together; each drops independently after its handshake (aw_done/w_done flags); when both done go to WRESP; handshakes in the same cycle are legal.
REQ-024 WRESP: bready=1; on bvalid go to DONE; bresp/rresp ignored.
REQ-025 DONE: m_ready=1 for exactly one cycle, m_dout stable; next state IDLE unconditionally.
REQ-026 Latency SHALL be: read = 3 cycles + AXI wait states; write = 3 cycles + wait states (strobe-accept to m_ready) with zero-wait slave.
REQ-027 m_dout SHALL hold its last read value through writes and idle.
REQ-028 Single-beat transfers only: arlen/awlen=0, burst INCR, wlast=1, ids=0 are top-level tie-offs.

Reset
REQ-029 On rst=1: state=IDLE, all valid/ready outputs 0, m_ready=0, m_dout=0, request registers 0, done flags 0, immediately and asynchronously.
REQ-030 Reset mid-transaction SHALL abandon the transaction; no completion pulse after release.

Structure
REQ-031 State encoding, AXI size/burst constants and tie-off values SHALL live in a shared package axi_pkg.
REQ-032 wstrb/size decode SHALL be a sub-module strb_gen (combinational); no other sub-modules.

Verification
REQ-033 Read m_a=0x9FC0_0010, arready/rvalid immediate, rdata=0xDEADBEEF -> araddr=0x1FC0_0010, m_ready pulse 3 cycles after strobe, m_dout=0xDEADBEEF.
REQ-034 Byte write m_a=0xA000_0003, m_din=0x1100_0000 -> awaddr=0x0000_0003, wstrb=1000, awsize=000, single m_ready after bvalid.
REQ-035 Write with awready 4 cycles late, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, WRESP entered only after both.
REQ-036 Read with rvalid delayed 10 cycles, m_strobe held -> exactly one AR handshake, one m_ready pulse.
REQ-037 rst asserted in RDATA -> arvalid/rready/m_ready 0 same cycle; after release, new strobe starts fresh AR.
